td4_prog_loader: RTL

- Upstream stage of the TD4 core: owns the 16x8 program store that the core's program counter addresses.
- Accepts a framed byte stream over a valid/ready interface and writes the program image into the store.
- Holds the core in reset until a complete, checksum-verified image has been committed.
- Provides the combinational instruction read port the core fetches from.

---
 rtl/td4_prog_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/td4_prog_loader.sv
// -----------------------------------------------------------------------------
// td4_prog_loader
// Program loader and instruction store for the TD4 core. A framed byte stream
// arrives over a valid/ready interface and is written into a 16x8 store. The
// core is held in reset until a complete image has been committed.
//
// Frame: SYNC_BYTE, COUNT (1..16), COUNT data bytes[, CSUM]
//
// Build option:
//   TD4_LOADER_CSUM_EN  defined   -> frame ends with a CSUM byte (mod-256 sum
//                                    of the data bytes); a mismatch rejects it.
//                       undefined -> no CSUM byte; commit follows the last
//                                    data byte, only a bad COUNT sets err.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   in_data     stream byte
//   in_valid    in_data valid this cycle
//   in_ready    loader accepts in_data this cycle (low only while committing)
//   cpu_addr    core program counter; only the low ADDR_W bits index the store
//   cpu_data    instruction at cpu_addr (combinational read)
//   cpu_hold    registered reset for the core; 1 = core held
//   busy        frame reception in progress
//   err         last frame rejected; sticky until the next valid COUNT
//   loaded_len  word count of the last committed image (0..16)
// -----------------------------------------------------------------------------
module td4_prog_loader #(
   parameter int                DEPTH     = 16,
   parameter int                ADDR_W    = 4,
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       cpu_addr,
   output logic [DATA_W-1:0] cpu_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              err,
   output logic [ADDR_W:0]   loaded_len
);

   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT,
      S_DATA,
`ifdef TD4_LOADER_CSUM_EN
      S_CSUM,
`endif
      S_COMMIT,
      S_RUN,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] store [DEPTH];
   logic [CNT_W-1:0]  ptr_q;
   logic [CNT_W-1:0]  cnt_q;
`ifdef TD4_LOADER_CSUM_EN
   logic [DATA_W-1:0] sum_q;
`endif

   logic xfer, is_sync, count_ok, last_data;
   logic clear_store, write_store, load_cnt, err_set, err_clr, commit;

   // Upper program-counter bits are deliberately ignored: the address wraps.
   logic unused_addr;
   assign unused_addr = ^cpu_addr[15:ADDR_W];

   assign in_ready  = (state_q != S_COMMIT);
   assign xfer      = in_valid && in_ready;
   assign is_sync   = (in_data == SYNC_BYTE);
   assign count_ok  = (in_data != '0) && (in_data <= DATA_W'(DEPTH));
   assign last_data = (ptr_q == cnt_q - CNT_W'(1));

   // Old contents remain visible during a same-cycle write; new data after the edge.
   assign cpu_data = store[cpu_addr[ADDR_W-1:0]];

   always_comb begin
      busy = (state_q == S_CNT) || (state_q == S_DATA) || (state_q == S_COMMIT);
`ifdef TD4_LOADER_CSUM_EN
      if (state_q == S_CSUM) busy = 1'b1;
`endif
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d     = state_q;
      clear_store = 1'b0;
      write_store = 1'b0;
      load_cnt    = 1'b0;
      err_set     = 1'b0;
      err_clr     = 1'b0;
      commit      = 1'b0;
      case (state_q)
         S_IDLE, S_RUN, S_ERR: begin
            if (xfer && is_sync) state_d = S_CNT;
         end
         S_CNT: begin
            if (xfer) begin
               if (count_ok) begin
                  clear_store = 1'b1;
                  load_cnt    = 1'b1;
                  err_clr     = 1'b1;
                  state_d     = S_DATA;
               end else begin
                  err_set = 1'b1;
                  state_d = S_ERR;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               write_store = 1'b1;
`ifdef TD4_LOADER_CSUM_EN
               if (last_data) state_d = S_CSUM;
`else
               if (last_data) state_d = S_COMMIT;
`endif
            end
         end
`ifdef TD4_LOADER_CSUM_EN
         S_CSUM: begin
            if (xfer) begin
               if (in_data == sum_q) begin
                  state_d = S_COMMIT;
               end else begin
                  err_set = 1'b1;
                  state_d = S_ERR;
               end
            end
         end
`endif
         S_COMMIT: begin
            commit  = 1'b1;
            state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         err        <= 1'b0;
         loaded_len <= '0;
         cpu_hold   <= 1'b1;
`ifdef TD4_LOADER_CSUM_EN
         sum_q      <= '0;
`endif
         // NOTE: the store is reset explicitly because the core may fetch it
         // after reset and must see 8'h00, so it maps to flops, not a RAM macro.
         for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      end else begin
         state_q <= state_d;
         // The core runs only while the FSM is (about to be) in RUN.
         cpu_hold <= (state_d != S_RUN);

         for (int i = 0; i < DEPTH; i++) begin
            if (clear_store)
               store[i] <= '0;
            else if (write_store && (ptr_q[ADDR_W-1:0] == ADDR_W'(i)))
               store[i] <= in_data;
         end

         if (load_cnt) begin
            ptr_q <= '0;
            cnt_q <= in_data[CNT_W-1:0];
         end else if (write_store) begin
            ptr_q <= ptr_q + CNT_W'(1);
         end

`ifdef TD4_LOADER_CSUM_EN
         if (load_cnt)
            sum_q <= '0;
         else if (write_store)
            sum_q <= sum_q + in_data;
`endif

         if (err_set)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;

         if (commit) loaded_len <= cnt_q;
      end
   end

endmodule
